// File: rtl/cpu_controller.sv
// Eight-phase fetch/execute sequencer for the 8-bit RISC CPU.
// Steps a registered phase counter and decodes the IR opcode into datapath strobes.
module cpu_controller #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       resume,
    input  logic [2:0] opcode,
    input  logic       is_zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   alu_op;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // HLT is taken on the phase-4 edge, so the frozen phase is always OP_FETCH.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (halted_q) begin
            if (!HALT_STICKY && resume) begin
                halted_d = 1'b0;
                phase_d  = INST_ADDR;
            end
        end else if (en) begin
            phase_d = phase_t'(phase_q + 3'd1);
            if (phase_q == OP_ADDR && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end
        end
    end

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            sel  = 1'b1;
            halt = 1'b1;
        end else begin
            unique case (phase_q)
                INST_ADDR:  sel = 1'b1;
                INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
                INST_LOAD:  begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
                IDLE:       begin sel = 1'b1; rd = 1'b1; end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: rd = alu_op;
                ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = (opcode == OP_SKZ) && is_zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: ;
            endcase
            // A stalled phase must not repeat a register load.
            if (!en) begin
                ld_ir  = 1'b0;
                inc_pc = 1'b0;
                ld_pc  = 1'b0;
                ld_ac  = 1'b0;
                wr     = 1'b0;
            end
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller (default HALT_STICKY=1).
// Strobe vectors are packed {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}.
module tb_cpu_controller;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       resume;
    logic [2:0] opcode;
    logic       is_zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, STO = 3'd6, JMP = 3'd7;

    localparam logic [8:0] S_NONE   = 9'b000000000;
    localparam logic [8:0] S_P0     = 9'b100000000;
    localparam logic [8:0] S_P1     = 9'b110000000;
    localparam logic [8:0] S_P2     = 9'b111000000;
    localparam logic [8:0] S_P3     = 9'b110000000;
    localparam logic [8:0] S_INC    = 9'b000100000;
    localparam logic [8:0] S_RD     = 9'b010000000;
    localparam logic [8:0] S_RD_AC  = 9'b010001000;
    localparam logic [8:0] S_DE     = 9'b000000010;
    localparam logic [8:0] S_WR_DE  = 9'b000000110;
    localparam logic [8:0] S_LDPC   = 9'b000010000;
    localparam logic [8:0] S_INC_H  = 9'b000100001;
    localparam logic [8:0] S_HALT_4 = 9'b000000001;
    localparam logic [8:0] S_HALTED = 9'b100000001;

    cpu_controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .resume  (resume),
        .opcode  (opcode),
        .is_zero (is_zero),
        .sel     (sel),
        .rd      (rd),
        .ld_ir   (ld_ir),
        .inc_pc  (inc_pc),
        .ld_pc   (ld_pc),
        .ld_ac   (ld_ac),
        .wr      (wr),
        .data_e  (data_e),
        .halt    (halt),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic e, input logic res,
                                 input logic [2:0] op, input logic z);
        rst_n   = r;
        en      = e;
        resume  = res;
        opcode  = op;
        is_zero = z;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] exp_phase,
                               input logic [8:0] exp_strobes);
        logic [8:0] got;
        #1;
        got = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
        compared++;
        assert (phase === exp_phase) else begin
            mismatched++;
            $display("[TB] FAIL %s phase: got %0d expected %0d", tag, phase, exp_phase);
            $error("[TB] %s phase got %0d expected %0d", tag, phase, exp_phase);
        end
        compared++;
        assert (got === exp_strobes) else begin
            mismatched++;
            $display("[TB] FAIL %s strobes: got %b expected %b", tag, got, exp_strobes);
            $error("[TB] %s strobes got %b expected %b", tag, got, exp_strobes);
        end
    endtask

    // Runs one full instruction from phase 0, checking every phase, ending back at phase 0.
    task automatic runInstr(input string tag, input logic [2:0] op, input logic z,
                            input logic [8:0] e4, input logic [8:0] e5,
                            input logic [8:0] e6, input logic [8:0] e7);
        logic [8:0] exp_s [8];
        exp_s[0] = S_P0; exp_s[1] = S_P1; exp_s[2] = S_P2; exp_s[3] = S_P3;
        exp_s[4] = e4;   exp_s[5] = e5;   exp_s[6] = e6;   exp_s[7] = e7;
        applyStimulus(1'b1, 1'b1, 1'b0, op, z);
        for (int p = 0; p < 8; p++) begin
            checkOutput($sformatf("%s_p%0d", tag, p), 3'(p), exp_s[p]);
            step();
        end
        checkOutput({tag, "_wrap"}, 3'd0, S_P0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, ADD, 1'b0);
        step();
        step();
        checkOutput("reset", 3'd0, S_P0);

        runInstr("add",    ADD, 1'b0, S_INC, S_RD,   S_RD,   S_RD_AC);
        runInstr("sto",    STO, 1'b0, S_INC, S_NONE, S_DE,   S_WR_DE);
        runInstr("skz_z1", SKZ, 1'b1, S_INC, S_NONE, S_INC,  S_NONE);
        runInstr("skz_z0", SKZ, 1'b0, S_INC, S_NONE, S_NONE, S_NONE);
        runInstr("jmp",    JMP, 1'b0, S_INC, S_NONE, S_LDPC, S_LDPC);

        // Stall at phase 2, then mid-instruction reset at phase 6.
        applyStimulus(1'b1, 1'b1, 1'b0, ADD, 1'b0);
        step();
        step();
        checkOutput("pre_stall", 3'd2, S_P2);
        applyStimulus(1'b1, 1'b0, 1'b0, ADD, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("stall_%0d", i), 3'd2, S_P1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, ADD, 1'b0);
        checkOutput("unstall", 3'd2, S_P2);
        for (int i = 0; i < 4; i++) step();
        checkOutput("at_p6", 3'd6, S_RD);
        applyStimulus(1'b0, 1'b1, 1'b0, ADD, 1'b0);
        step();
        checkOutput("mid_reset", 3'd0, S_P0);

        // HLT: stall in phase 4 first, then halt and stay halted.
        applyStimulus(1'b1, 1'b1, 1'b0, HLT, 1'b0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("hlt_p4", 3'd4, S_INC_H);
        applyStimulus(1'b1, 1'b0, 1'b0, HLT, 1'b0);
        step();
        checkOutput("hlt_p4_stall", 3'd4, S_HALT_4);
        applyStimulus(1'b1, 1'b1, 1'b0, HLT, 1'b0);
        step();
        checkOutput("halted_entry", 3'd5, S_HALTED);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, i[0], ADD, 1'b1);
            step();
            checkOutput($sformatf("halted_%0d", i), 3'd5, S_HALTED);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, ADD, 1'b0);
        step();
        checkOutput("halt_reset", 3'd0, S_P0);
        applyStimulus(1'b1, 1'b1, 1'b0, ADD, 1'b0);
        step();
        checkOutput("post_halt_run", 3'd1, S_P1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
